// File: rtl/svcs_frame_pkg.sv
// SVCS frame receiver shared definitions: frame type codes, header field
// positions, error codes and receive FSM state encoding.
// Optional feature macro used by importers: SVCS_FRAME_RX_CHKSUM_EN.
package svcs_frame_pkg;

  typedef enum logic [7:0] {
    SVCS_INT   = 8'h01,
    SVCS_REAL  = 8'h02,
    SVCS_INTV  = 8'h03,
    SVCS_REALV = 8'h04
  } svcs_type_e;

  localparam int HDR_TYPE_MSB = 31;
  localparam int HDR_TYPE_LSB = 24;
  localparam int HDR_CNT_MSB  = 15;
  localparam int HDR_CNT_LSB  = 0;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_TYPE   = 2'd1,
    ERR_COUNT  = 2'd2,
    ERR_CHKSUM = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_INT_PAY,
    ST_REAL_LO,
    ST_REAL_HI,
    ST_CHK
  } rx_state_e;

  // Integer elements travel as 32-bit two's complement words.
  function automatic logic [63:0] sext32(input logic [31:0] w);
    return {{32{w[31]}}, w};
  endfunction

endpackage

// File: rtl/svcs_out_reg.sv
// One-entry valid/ready holding register for a decoded element.
// Ports: load/in_* write side (only when ready), valid/data/is_real/idx/last
// read side, ready_out = space available (empty or draining this cycle).
module svcs_out_reg #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [63:0]      in_data,
  input  logic             in_is_real,
  input  logic [CNT_W-1:0] in_idx,
  input  logic             in_last,
  output logic             space,
  input  logic             ready,
  output logic             valid,
  output logic [63:0]      data,
  output logic             is_real,
  output logic [CNT_W-1:0] idx,
  output logic             last
);

  // Accepting while the held element drains gives back-to-back throughput.
  assign space = !valid || ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      data    <= '0;
      is_real <= 1'b0;
      idx     <= '0;
      last    <= 1'b0;
    end else begin
      if (load) begin
        valid   <= 1'b1;
        data    <= in_data;
        is_real <= in_is_real;
        idx     <= in_idx;
        last    <= in_last;
      end else if (ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/svcs_frame_rx.sv
// SVCS frame receiver: decodes 32-bit socket words into typed 64-bit elements.
// Ports: s_valid/s_ready/s_data word input; m_valid/m_ready/m_data/m_is_real/
// m_idx/m_last element output; frm_done/err/err_code status pulses; busy.
// Optional SVCS_FRAME_RX_CHKSUM_EN: trailing XOR checksum word checked in ST_CHK.
module svcs_frame_rx
  import svcs_frame_pkg::*;
#(
  parameter int MAX_LEN = 256,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [63:0]      m_data,
  output logic             m_is_real,
  output logic [CNT_W-1:0] m_idx,
  output logic             m_last,
  output logic             frm_done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic             busy
);

  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [31:0]      lo_q, lo_d;
  err_code_e        err_code_q, code_now;
  logic             rdy_en_q;
`ifdef SVCS_FRAME_RX_CHKSUM_EN
  logic [31:0]      chk_q, chk_d;
`endif

  logic             accept;
  logic             out_space;
  logic             load;
  logic [63:0]      ld_data;
  logic             ld_real;
  logic             ld_last;
  logic             last_elem;
  logic [7:0]       hdr_type;
  logic [15:0]      hdr_cnt;
  logic             type_ok;
  logic             cnt_ok;
  logic             hdr_real;

  // Held low through reset and released one cycle after rst_n rises.
  always_comb begin
    s_ready = rdy_en_q;
    if (state_q == ST_INT_PAY || state_q == ST_REAL_LO || state_q == ST_REAL_HI) begin
      s_ready = rdy_en_q && out_space;
    end
  end

  assign accept    = s_valid && s_ready;
  assign hdr_type  = s_data[HDR_TYPE_MSB:HDR_TYPE_LSB];
  assign hdr_cnt   = s_data[HDR_CNT_MSB:HDR_CNT_LSB];
  assign last_elem = (idx_q + CNT_W'(1)) == cnt_q;
  assign busy      = state_q != ST_HDR;
  assign err_code  = err ? code_now : err_code_q;

  always_comb begin
    type_ok  = 1'b1;
    cnt_ok   = 1'b0;
    hdr_real = 1'b0;
    case (hdr_type)
      SVCS_INT:   cnt_ok = hdr_cnt == 16'd1;
      SVCS_REAL: begin
        cnt_ok   = hdr_cnt == 16'd1;
        hdr_real = 1'b1;
      end
      SVCS_INTV:  cnt_ok = hdr_cnt != 16'd0 && hdr_cnt <= MAX_LEN_W;
      SVCS_REALV: begin
        cnt_ok   = hdr_cnt != 16'd0 && hdr_cnt <= MAX_LEN_W;
        hdr_real = 1'b1;
      end
      default:    type_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    lo_d     = lo_q;
`ifdef SVCS_FRAME_RX_CHKSUM_EN
    chk_d    = chk_q;
`endif
    load     = 1'b0;
    ld_data  = '0;
    ld_real  = 1'b0;
    ld_last  = 1'b0;
    frm_done = 1'b0;
    err      = 1'b0;
    code_now = ERR_NONE;
    case (state_q)
      ST_HDR: begin
        if (accept) begin
          if (!type_ok) begin
            err      = 1'b1;
            code_now = ERR_TYPE;
          end else if (!cnt_ok) begin
            err      = 1'b1;
            code_now = ERR_COUNT;
          end else begin
            state_d = hdr_real ? ST_REAL_LO : ST_INT_PAY;
            cnt_d   = hdr_cnt[CNT_W-1:0];
            idx_d   = '0;
`ifdef SVCS_FRAME_RX_CHKSUM_EN
            chk_d   = s_data;
`endif
          end
        end
      end
      ST_INT_PAY, ST_REAL_HI: begin
        if (accept) begin
          load    = 1'b1;
          ld_real = state_q == ST_REAL_HI;
          ld_data = ld_real ? {s_data, lo_q} : sext32(s_data);
          ld_last = last_elem;
`ifdef SVCS_FRAME_RX_CHKSUM_EN
          chk_d   = chk_q ^ s_data;
`endif
          if (last_elem) begin
`ifdef SVCS_FRAME_RX_CHKSUM_EN
            state_d  = ST_CHK;
`else
            state_d  = ST_HDR;
            frm_done = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + CNT_W'(1);
            state_d = ld_real ? ST_REAL_LO : ST_INT_PAY;
          end
        end
      end
      ST_REAL_LO: begin
        if (accept) begin
          lo_d    = s_data;
          state_d = ST_REAL_HI;
`ifdef SVCS_FRAME_RX_CHKSUM_EN
          chk_d   = chk_q ^ s_data;
`endif
        end
      end
`ifdef SVCS_FRAME_RX_CHKSUM_EN
      ST_CHK: begin
        if (accept) begin
          state_d = ST_HDR;
          if (s_data == chk_q) begin
            frm_done = 1'b1;
          end else begin
            err      = 1'b1;
            code_now = ERR_CHKSUM;
          end
        end
      end
`endif
      default: state_d = ST_HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_HDR;
      cnt_q      <= '0;
      idx_q      <= '0;
      lo_q       <= '0;
      err_code_q <= ERR_NONE;
      rdy_en_q   <= 1'b0;
`ifdef SVCS_FRAME_RX_CHKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      lo_q     <= lo_d;
      rdy_en_q <= 1'b1;
      if (err) begin
        err_code_q <= code_now;
      end
`ifdef SVCS_FRAME_RX_CHKSUM_EN
      chk_q    <= chk_d;
`endif
    end
  end

  svcs_out_reg #(
    .CNT_W(CNT_W)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .in_data   (ld_data),
    .in_is_real(ld_real),
    .in_idx    (idx_q),
    .in_last   (ld_last),
    .space     (out_space),
    .ready     (m_ready),
    .valid     (m_valid),
    .data      (m_data),
    .is_real   (m_is_real),
    .idx       (m_idx),
    .last      (m_last)
  );

endmodule

// File: tb/tb_svcs_frame_rx.sv
module tb_svcs_frame_rx;
  localparam int MAX_LEN = 256;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  logic             clk;
  logic             rst_n;
  logic             s_valid;
  logic             s_ready;
  logic [31:0]      s_data;
  logic             m_valid;
  logic             m_ready;
  logic [63:0]      m_data;
  logic             m_is_real;
  logic [CNT_W-1:0] m_idx;
  logic             m_last;
  logic             frm_done;
  logic             err;
  logic [1:0]       err_code;
  logic             busy;

  typedef struct packed {
    logic [63:0]      data;
    logic             is_real;
    logic [CNT_W-1:0] idx;
    logic             last;
  } elem_t;

  elem_t       exp_q[$];
  int          exp_err_q[$];
  logic [63:0] el_q[$];
  int          exp_done = 0;
  int          got_done = 0;
  int          n_vec = 0;
  int          n_mis = 0;
  int          mr_mode = 0;  // 0: always ready, 1: random, 2: held low

  svcs_frame_rx #(.MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_is_real(m_is_real), .m_idx(m_idx), .m_last(m_last),
    .frm_done(frm_done), .err(err), .err_code(err_code), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    case (mr_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_mis++;
    $display("FAIL %s", name);
  endtask

  // Scoreboard monitor: pops expectations whenever the DUT hands something over.
  elem_t cur, prev, e;
  bit    stalled = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 0;
    end else begin
      cur = '{data: m_data, is_real: m_is_real, idx: m_idx, last: m_last};
      if (stalled && m_valid) check("hold_stable", cur, prev);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_element");
        else begin
          e = exp_q.pop_front();
          check("element", cur, e);
        end
      end
      stalled = m_valid && !m_ready;
      prev = cur;
      if (frm_done) got_done++;
      if (err) begin
        if (exp_err_q.size() == 0) fail_now("unexpected_err");
        else check("err_code", 80'(err_code), 80'(exp_err_q.pop_front()));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the word is accepted.
  task automatic put_word(input logic [31:0] w);
    int t = 0;
    s_valid = 1'b1;
    s_data  = w;
    @(negedge clk);
    while (!s_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) fail_now("s_ready_timeout");
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic fill_rand(input int n);
    el_q.delete();
    for (int i = 0; i < n; i++) el_q.push_back({$urandom, $urandom});
  endtask

  // Reference model: builds the word stream from the frame rules and records
  // what the receiver must produce for it.
  task automatic send_frame(input logic [7:0] typ, input int cnt, input bit bad_chk,
                            input bit model_elems, input bit gaps);
    logic [31:0] w[$];
    logic [31:0] x;
    bit          is_real, type_ok, cnt_ok;
    elem_t       ex;
    is_real = (typ == 8'h02) || (typ == 8'h04);
    type_ok = (typ >= 8'h01) && (typ <= 8'h04);
    cnt_ok  = (typ <= 8'h02) ? (cnt == 1) : (cnt >= 1 && cnt <= MAX_LEN);
    w.push_back({typ, 8'($urandom), 16'(cnt)});
    if (!type_ok || !cnt_ok) begin
      exp_err_q.push_back(type_ok ? 2 : 1);
      put_word(w[0]);
      return;
    end
    for (int i = 0; i < cnt; i++) begin
      ex.idx     = CNT_W'(i);
      ex.last    = (i == cnt - 1);
      ex.is_real = is_real;
      if (is_real) begin
        ex.data = el_q[i];
        w.push_back(el_q[i][31:0]);
        w.push_back(el_q[i][63:32]);
      end else begin
        ex.data = 64'($signed(el_q[i][31:0]));
        w.push_back(el_q[i][31:0]);
      end
      if (model_elems) exp_q.push_back(ex);
    end
`ifdef SVCS_FRAME_RX_CHKSUM_EN
    x = '0;
    foreach (w[i]) x = x ^ w[i];
    w.push_back(bad_chk ? ~x : x);
    if (bad_chk) exp_err_q.push_back(3);
    else exp_done++;
`else
    x = 32'(bad_chk);
    exp_done = exp_done + 1 + 0 * int'(x);
`endif
    foreach (w[i]) begin
      put_word(w[i]);
      if (gaps) repeat ($urandom_range(0, 2)) @(posedge clk);
      if (gaps) #1;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", 80'(s_ready), 80'(0));
    check("rst_m_valid", 80'(m_valid), 80'(0));
    check("rst_busy", 80'(busy), 80'(0));
    check("rst_pulses", {78'(0), frm_done, err}, 80'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {m_valid, m_data, m_is_real, m_last, frm_done, err, busy}, 80'(0));
    check("reset_idx_code", {m_idx, err_code}, 80'(0));
    check("reset_s_ready", 80'(s_ready), 80'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_reset_s_ready", 80'(s_ready), 80'(1));
    @(posedge clk);
    #1;

    // INT -2
    el_q = '{64'h0000_0000_FFFF_FFFE};
    send_frame(8'h01, 1, 0, 1, 0);
    drain();
    check("done_int", 80'(got_done), 80'(exp_done));

    // REALV 1.0, 2.0
    el_q = '{64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000};
    send_frame(8'h04, 2, 0, 1, 0);
    drain();

    // INTV 4 with consumer stall after the first element
    fill_rand(4);
    fork
      send_frame(8'h03, 4, 0, 1, 0);
      begin
        int t = 0;
        @(negedge clk);
        while (!m_valid && t < 100) begin
          @(negedge clk);
          t++;
        end
        mr_mode = 2;
        repeat (3) begin
          @(negedge clk);
          check("stall_s_ready", 80'(s_ready), 80'(0));
        end
        mr_mode = 0;
      end
    join
    drain();

    // Header errors, then a clean frame
    send_frame(8'h07, 1, 0, 1, 0);
    send_frame(8'h01, 2, 0, 1, 0);
    send_frame(8'h03, 0, 0, 1, 0);
    send_frame(8'h04, MAX_LEN + 1, 0, 1, 0);
    fill_rand(3);
    send_frame(8'h03, 3, 0, 1, 0);
    drain();
    check("err_code_holds", 80'(err_code), 80'(2));

    // Full-length vector
    fill_rand(MAX_LEN);
    send_frame(8'h03, MAX_LEN, 0, 1, 0);
    drain();
    check("done_maxlen", 80'(got_done), 80'(exp_done));

    // Randomized traffic with random backpressure and gaps
    mr_mode = 1;
    for (int f = 0; f < 30; f++) begin
      int r, c;
      logic [7:0] typ;
      r = $urandom_range(0, 9);
      typ = 8'($urandom_range(1, 4));
      c = (typ <= 8'h02) ? 1 : $urandom_range(1, 8);
      if (r == 0) typ = 8'($urandom_range(5, 255));
      if (r == 1) c = (typ <= 8'h02) ? $urandom_range(2, 5) : 0;
      fill_rand(8);
      send_frame(typ, c, ($urandom_range(0, 7) == 0), 1, 1);
    end
    mr_mode = 0;
    drain();

    // Reset with a pending element and a header already taken
    mr_mode = 2;
    fill_rand(1);
    send_frame(8'h01, 1, 0, 0, 0);
    put_word({8'h04, 8'h00, 16'd2});
    @(negedge clk);
    check("pending_before_rst", 80'(m_valid), 80'(1));
    @(posedge clk);
    #1;
    do_reset(2);
    mr_mode = 0;

    // Reset after the low word of a real
    put_word({8'h04, 8'h00, 16'd2});
    put_word(32'h1234_5678);
    do_reset(2);

    fill_rand(1);
    send_frame(8'h01, 1, 0, 1, 0);
    drain();
`ifdef SVCS_FRAME_RX_CHKSUM_EN
    fill_rand(1);
    send_frame(8'h01, 1, 1, 1, 0);
    drain();
`endif

    check("done_total", 80'(got_done), 80'(exp_done));
    check("err_pending", 80'(exp_err_q.size()), 80'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
